// File: rtl/serial_add_sub_if.sv
// Bundles the operand/request and result/status signals of serial_add_sub.
// The master modport belongs to the requester; the slave modport belongs to the adder.
interface serial_add_sub_if #(
    parameter int WIDTH = 16
);
    logic             Start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Sub;
    logic [WIDTH-1:0] S;
    logic             Cout;
    logic             Ovr;
    logic             Zero;
    logic             Busy;
    logic             Done;
    logic [1:0]       state_dbg;

    modport master (
        output Start, A, B, Sub,
        input  S, Cout, Ovr, Zero, Busy, Done, state_dbg
    );

    modport slave (
        input  Start, A, B, Sub,
        output S, Cout, Ovr, Zero, Busy, Done, state_dbg
    );
endinterface

// File: rtl/serial_add_sub.sv
// Digit-serial adder/subtractor: processes DIGIT bits per clock, LSB slice first,
// producing a WIDTH-bit result plus carry, signed-overflow and zero flags.
module serial_add_sub #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic          Clk,
    input  logic          Rst,
    serial_add_sub_if.slave bus
);
    localparam int N     = WIDTH / DIGIT;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    // Handshake: Start is a request accepted on any rising edge where Busy=0
    // (IDLE or DONE); Done is a one-cycle valid strobe for S/Cout/Ovr/Zero,
    // which then hold until the next accepted Start.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             sub_q, sub_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic             cout_q, cout_d;
    logic             ovr_q, ovr_d;
    logic             zero_q, zero_d;

    logic [DIGIT-1:0]       slice_a;
    logic [DIGIT-1:0]       slice_b;
    logic [DIGIT-1:0]       slice_sum;
    logic                   slice_cmsb;
    logic                   slice_cout;
    logic [WIDTH+DIGIT-1:0] s_shift;

    assign slice_a = a_q[DIGIT-1:0];
    assign slice_b = b_q[DIGIT-1:0] ^ {DIGIT{sub_q}};

    // Ripple across one slice; the carry entering the top bit is kept for Ovr.
    always_comb begin : slice_add
        logic c;
        c          = carry_q;
        slice_sum  = '0;
        slice_cmsb = 1'b0;
        for (int i = 0; i < DIGIT; i++) begin
            if (i == DIGIT - 1) slice_cmsb = c;
            slice_sum[i] = slice_a[i] ^ slice_b[i] ^ c;
            c = (slice_a[i] & slice_b[i]) | (c & (slice_a[i] ^ slice_b[i]));
        end
        slice_cout = c;
    end

    // New slice enters at the top of S; after N slices it sits fully aligned.
    assign s_shift = {slice_sum, s_q};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        sub_d   = sub_q;
        s_d     = s_q;
        cout_d  = cout_q;
        ovr_d   = ovr_q;
        zero_d  = zero_q;
        case (state_q)
            IDLE, DONE: begin
                if (bus.Start) begin
                    a_d     = bus.A;
                    b_d     = bus.B;
                    sub_d   = bus.Sub;
                    carry_d = bus.Sub;
                    cnt_d   = '0;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                a_d     = a_q >> DIGIT;
                b_d     = b_q >> DIGIT;
                carry_d = slice_cout;
                s_d     = s_shift[WIDTH+DIGIT-1:DIGIT];
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(N - 1)) begin
                    state_d = DONE;
                    cout_d  = slice_cout;
                    ovr_d   = slice_cmsb ^ slice_cout;
                    zero_d  = (s_d == '0);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sub_q   <= 1'b0;
            s_q     <= '0;
            cout_q  <= 1'b0;
            ovr_q   <= 1'b0;
            zero_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sub_q   <= sub_d;
            s_q     <= s_d;
            cout_q  <= cout_d;
            ovr_q   <= ovr_d;
            zero_q  <= zero_d;
        end
    end

    assign bus.S         = s_q;
    assign bus.Cout      = cout_q;
    assign bus.Ovr       = ovr_q;
    assign bus.Zero      = zero_q;
    assign bus.Busy      = (state_q == RUN);
    assign bus.Done      = (state_q == DONE);
    assign bus.state_dbg = state_q;
endmodule

// File: tb/tb_serial_add_sub.sv
// Bench for serial_add_sub: directed vectors and corner sequences on a 16/4 instance,
// plus randomized regressions on four WIDTH/DIGIT configurations against an arithmetic model.
module tb_serial_add_sub;
    logic clk = 1'b0;
    logic rst;
    logic rst_r;
    bit   reg_go = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    typedef struct packed {
        logic        zero;
        logic        ovr;
        logic        cout;
        logic [63:0] s;
    } res_t;

    // Reference: integer arithmetic on unsigned/signed interpretations (w <= 32).
    function automatic res_t golden(int w, logic [63:0] a, logic [63:0] b, logic sub);
        longint lim, ua, ub, sa, sb, ur, sr;
        res_t r;
        lim    = longint'(1) << w;
        ua     = longint'(a);
        ub     = longint'(b);
        sa     = a[w-1] ? ua - lim : ua;
        sb     = b[w-1] ? ub - lim : ub;
        ur     = sub ? ua - ub : ua + ub;
        sr     = sub ? sa - sb : sa + sb;
        r.cout = sub ? (ua >= ub) : (ur >= lim);
        r.ovr  = (sr >= lim / 2) || (sr < -(lim / 2));
        r.s    = 64'(ur) & 64'(lim - 1);
        r.zero = (r.s == 64'd0);
        return r;
    endfunction

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    // ---------------- directed instance (16,4) ----------------
    localparam int DW = 16;
    localparam int DN = 4;

    serial_add_sub_if #(.WIDTH(DW)) dif ();
    serial_add_sub #(.WIDTH(DW), .DIGIT(4)) u_dut (
        .Clk (clk),
        .Rst (rst),
        .bus (dif)
    );

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
        logic        sub;
        logic [15:0] s;
        logic        cout;
        logic        ovr;
        logic        zero;
    } vec_t;

    vec_t vecs[8];
    logic [18:0] exp_q[$];

    task automatic check_reset(input string name);
        check(name, 128'({dif.Done, dif.Busy, dif.Zero, dif.Ovr, dif.Cout, dif.S}),
              128'({5'b00100, 16'h0000}));
    endtask

    // Call at a negedge; returns latency in negedges until Done (0 if it never came).
    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic sub,
                          output int lat);
        dif.Start = 1'b1;
        dif.A     = a;
        dif.B     = b;
        dif.Sub   = sub;
        lat       = 0;
        for (int c = 1; c <= DN + 3; c++) begin
            @(negedge clk);
            dif.Start = 1'b0;
            dif.A     = 16'($urandom);
            dif.B     = 16'($urandom);
            dif.Sub   = 1'($urandom);
            if (dif.Done) begin
                lat = c;
                break;
            end
        end
    endtask

    // ---------------- regression instances ----------------
    localparam int CW[4] = '{4, 16, 16, 32};
    localparam int CD[4] = '{1, 4, 16, 8};
    localparam int NOPS  = 10000;

    for (genvar gi = 0; gi < 4; gi++) begin : g_reg
        localparam int W = CW[gi];
        localparam int D = CD[gi];
        localparam int N = W / D;

        serial_add_sub_if #(.WIDTH(W)) rif ();
        serial_add_sub #(.WIDTH(W), .DIGIT(D)) u_dut (
            .Clk (clk),
            .Rst (rst_r),
            .bus (rif)
        );

        bit fin = 1'b0;

        initial begin
            logic [W-1:0] a, b;
            logic         sub;
            res_t         exp;
            int           lat;
            rif.Start = 1'b0;
            rif.A     = '0;
            rif.B     = '0;
            rif.Sub   = 1'b0;
            wait (reg_go);
            for (int k = 0; k < NOPS; k++) begin
                a   = W'($urandom);
                b   = W'($urandom);
                sub = 1'($urandom);
                if ($urandom_range(0, 7) == 0) @(negedge clk);
                rif.Start = 1'b1;
                rif.A     = a;
                rif.B     = b;
                rif.Sub   = sub;
                exp       = golden(W, 64'(a), 64'(b), sub);
                lat       = 0;
                for (int c = 1; c <= N + 3; c++) begin
                    @(negedge clk);
                    rif.Start = 1'b0;
                    rif.A     = W'($urandom);
                    rif.B     = W'($urandom);
                    rif.Sub   = 1'($urandom);
                    if (rif.Done) begin
                        lat = c;
                        break;
                    end
                end
                check($sformatf("reg%0d_lat", gi), 128'(lat), 128'(N + 1));
                check($sformatf("reg%0d_res", gi),
                      128'({rif.Zero, rif.Ovr, rif.Cout, 64'(rif.S)}), 128'(exp));
            end
            fin = 1'b1;
        end
    end

    // ---------------- main sequence ----------------
    initial begin
        int   lat;
        bit   saw;
        res_t g;
        logic [18:0] e;

        vecs[0] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0};
        vecs[1] = '{16'h0005, 16'h0005, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1};
        vecs[2] = '{16'h0003, 16'h0005, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0};
        vecs[4] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
        vecs[5] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1};
        vecs[6] = '{16'h0000, 16'h0001, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0};
        vecs[7] = '{16'h7FFF, 16'hFFFF, 1'b1, 16'h8000, 1'b0, 1'b1, 1'b0};

        // clock/reset
        rst       = 1'b1;
        rst_r     = 1'b1;
        dif.Start = 1'b0;
        dif.A     = '0;
        dif.B     = '0;
        dif.Sub   = 1'b0;
        repeat (3) @(negedge clk);
        check_reset("reset_state");
        check("reset_fsm", 128'(dif.state_dbg), 128'(0));
        rst    = 1'b0;
        rst_r  = 1'b0;
        reg_go = 1'b1;

        // table-driven vectors
        for (int i = 0; i < 8; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].sub, lat);
            check($sformatf("vec%0d_lat", i), 128'(lat), 128'(DN + 1));
            check($sformatf("vec%0d_res", i),
                  128'({dif.Zero, dif.Ovr, dif.Cout, dif.S}),
                  128'({vecs[i].zero, vecs[i].ovr, vecs[i].cout, vecs[i].s}));
            @(negedge clk);
            check($sformatf("vec%0d_hold", i),
                  128'({dif.Done, dif.Busy, dif.Zero, dif.Ovr, dif.Cout, dif.S}),
                  128'({2'b00, vecs[i].zero, vecs[i].ovr, vecs[i].cout, vecs[i].s}));
        end

        // Start held high, operands changing every cycle: captures at 0,5,10,15
        for (int i = 0; i <= 20; i++) begin
            if (i > 0) begin
                check($sformatf("hs_done%0d", i), 128'(dif.Done), 128'(i % 5 == 0));
                if (dif.Done) begin
                    check("hs_pending", 128'(exp_q.size() > 0), 128'(1));
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        check($sformatf("hs_res%0d", i),
                              128'({dif.Zero, dif.Ovr, dif.Cout, dif.S}), 128'(e));
                    end
                end
            end
            if (i < 20) begin
                dif.Start = 1'b1;
                dif.A     = 16'($urandom);
                dif.B     = 16'($urandom);
                dif.Sub   = 1'($urandom);
                if (i % 5 == 0) begin
                    g = golden(DW, 64'(dif.A), 64'(dif.B), dif.Sub);
                    exp_q.push_back({g.zero, g.ovr, g.cout, g.s[15:0]});
                end
                @(negedge clk);
            end else begin
                dif.Start = 1'b0;
            end
        end
        check("hs_drained", 128'(exp_q.size()), 128'(0));

        // Rst wins over Start on the same edge
        @(negedge clk);
        rst       = 1'b1;
        dif.Start = 1'b1;
        dif.A     = 16'h1111;
        dif.B     = 16'h2222;
        @(negedge clk);
        check_reset("rst_prio");
        rst       = 1'b0;
        dif.Start = 1'b0;
        @(negedge clk);
        check("rst_prio_idle", 128'(dif.Busy), 128'(0));

        // Rst two cycles into RUN aborts without Done
        dif.Start = 1'b1;
        dif.A     = 16'h1234;
        dif.B     = 16'h0F0F;
        dif.Sub   = 1'b0;
        @(negedge clk);
        dif.Start = 1'b0;
        check("abort_busy", 128'(dif.Busy), 128'(1));
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_reset("abort_reset");
        saw = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (dif.Done) saw = 1'b1;
        end
        check("abort_no_done", 128'(saw), 128'(0));
        run_op(16'h1234, 16'h0F0F, 1'b0, lat);
        g = golden(DW, 64'h1234, 64'h0F0F, 1'b0);
        check("after_abort_lat", 128'(lat), 128'(DN + 1));
        check("after_abort_res", 128'({dif.Zero, dif.Ovr, dif.Cout, dif.S}),
              128'({g.zero, g.ovr, g.cout, g.s[15:0]}));

        // wait for the regressions, bounded
        for (int t = 0; t < 80000; t++) begin
            if (g_reg[0].fin && g_reg[1].fin && g_reg[2].fin && g_reg[3].fin) break;
            @(negedge clk);
        end
        check("reg_finished",
              128'({g_reg[3].fin, g_reg[2].fin, g_reg[1].fin, g_reg[0].fin}), 128'(4'hF));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/serial_add_sub.md
SERIAL_ADD_SUB -- requirements
Module: serial_add_sub

Interface
REQ-001 Parameter WIDTH, default 16, operand and result width in bits; legal values 4 to 64.
REQ-002 Parameter DIGIT, default 4, bits processed per clock; 1 <= DIGIT <= WIDTH and WIDTH mod DIGIT = 0; N = WIDTH/DIGIT.
REQ-003 Clk  input  1  single clock; all state updates on rising edge.
REQ-004 Rst  input  1  reset, synchronous, active-high.
REQ-005 Start  input  1  request to begin an operation; sampled on rising edge.
REQ-006 A  input  WIDTH  operand A, two's complement or unsigned.
REQ-007 B  input  WIDTH  operand B.
REQ-008 Sub  input  1  mode: 0 = A+B, 1 = A-B.
REQ-009 S  output  WIDTH  registered result.
REQ-010 Cout  output  1  carry out of the MSB (for subtract, 1 = no borrow).
REQ-011 Ovr  output  1  signed overflow flag.
REQ-012 Zero  output  1  1 when S is all zeros.
REQ-013 Busy  output  1  1 while an operation is in progress.
REQ-014 Done  output  1  single-cycle pulse marking valid results.

Function
REQ-015 The FSM SHALL have states IDLE, RUN and DONE.
REQ-016 In IDLE or DONE, Start=1 at an edge SHALL capture A, B and Sub into internal registers, clear the digit counter, load internal carry with Sub, and enter RUN.
REQ-017 In RUN, Start SHALL be ignored, and changes on A, B and Sub SHALL have no effect on the operation in progress.
REQ-018 Each RUN edge SHALL add one DIGIT-bit slice, LSB slice first: slice(A) + (slice(B) XOR {DIGIT{Sub}}) + carry; the slice sum is stored in S and the carry register updated.
REQ-019 After the N-th RUN edge, the FSM SHALL enter DONE. Cout = final carry; Ovr = carry into MSB XOR carry out of MSB; Zero = (S == 0).
REQ-020 Latency: with Start captured at edge 0, Done SHALL be 1 for exactly the one cycle following edge N; Busy SHALL be 1 for the cycles following edges 0..N-1.
REQ-021 DONE SHALL last one cycle. Without Start it returns to IDLE; with Start it re-enters RUN directly, giving back-to-back throughput of one result per N+1 cycles.
REQ-022 S, Cout, Ovr and Zero SHALL hold their final values from DONE through IDLE until the next accepted Start.
REQ-023 S, Cout, Ovr and Zero SHALL be undefined-for-use while Busy=1; they are valid only when Done=1 or in IDLE after a completed operation.
REQ-024 Arithmetic SHALL be modulo 2^WIDTH. Results SHALL be bit-identical to a single-cycle WIDTH-bit ripple adder/subtractor with carry-in = Sub and B XORed with Sub.
REQ-025 DIGIT = WIDTH SHALL be supported: N = 1, so Done is 1 in the cycle after edge 1.

Reset
REQ-026 Rst=1 at an edge SHALL force IDLE; clear S, Cout, Ovr, Busy, Done, the counter, carry and operand registers to 0; and set Zero to 1. Rst has priority over Start.
REQ-027 Rst asserted during RUN SHALL abort the operation with no Done pulse. The first Start after Rst deasserts SHALL behave as from a fresh reset.

Verification
REQ-028 WIDTH=16, DIGIT=4: A=0x7FFF, B=0x0001, Sub=0 -> Done at edge 4, S=0x8000, Cout=0, Ovr=1, Zero=0.
REQ-029 A=0x0005, B=0x0005, Sub=1 -> S=0x0000, Cout=1, Ovr=0, Zero=1; A=0x0003, B=0x0005, Sub=1 -> S=0xFFFE, Cout=0, Ovr=0.
REQ-030 A=0x8000, B=0x0001, Sub=1 -> S=0x7FFF, Cout=1, Ovr=1; A=0xFFFF, B=0x0001, Sub=0 -> S=0x0000, Cout=1, Ovr=0, Zero=1.
REQ-031 Start held high with operands changed every cycle -> only the first operands are used; results every 5 cycles, Done one cycle wide, results match each captured set.
REQ-032 Rst pulsed 2 cycles after Start -> no Done, all outputs 0 except Zero=1; a new Start then completes normally with correct S.
REQ-033 Random regression for (WIDTH, DIGIT) = (4,1), (16,4), (16,16), (32,8), >=10k operations each -> S, Cout, Ovr and Zero match a golden ripple-adder model.
